// File: rtl/axi_lite_apb_pkg.sv
// Shared types and constants for the AXI4-Lite to APB bridge.
package axi_lite_apb_pkg;

   // Bridge FSM states: one AXI-Lite transaction in flight at a time.
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      SETUP  = 3'd1,
      ACCESS = 3'd2,
      WRESP  = 3'd3,
      RRESP  = 3'd4
   } bridge_state_t;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   // Width of the ACCESS timeout counter: enough to hold TIMEOUT_CYC itself.
   // Kept at least one bit so a disabled timeout (0) still elaborates.
   function automatic int tcnt_width(input int timeout_cyc);
      int w;
      w = $clog2(timeout_cyc + 1);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/axi_lite_to_apb_bridge_timeout.sv
// ACCESS-phase wait counter. Cleared while in SETUP, counts ACCESS cycles
// without PREADY, and saturates once it reaches TIMEOUT_CYC.
module apb_timeout_cnt
   import axi_lite_apb_pkg::*;
#(
   parameter int TIMEOUT_CYC = 256
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int CW = tcnt_width(TIMEOUT_CYC);

   logic [CW-1:0] cnt;

   // Counter register: clear has priority, then saturating increment.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (clear) begin
         cnt <= '0;
      end else if (enable && !expired) begin
         cnt <= cnt + CW'(1);
      end
   end

   // A TIMEOUT_CYC of zero disables the abort entirely.
   assign expired = (TIMEOUT_CYC != 0) && (cnt == CW'(TIMEOUT_CYC));

endmodule

// File: rtl/axi_lite_to_apb_bridge.sv
// AXI4-Lite slave to APB master bridge. Accepts one read or write at a time,
// runs it as one APB SETUP/ACCESS transfer and returns the APB status as the
// AXI response. Out-of-range addresses are answered with DECERR locally.
//
// Handshake: every AXI channel follows valid/ready; a transfer happens on a
// rising edge where both are high. AWREADY/WREADY (together) or ARREADY are
// high only in IDLE for the granted request, never while reset is asserted.
module axi_lite_to_apb_bridge
   import axi_lite_apb_pkg::*;
#(
   parameter int AW_AXI      = 32,
   parameter int DW_AXI      = 32,
   parameter int AW_APB      = 16,
   parameter int DW_APB      = 32,
   parameter int TIMEOUT_CYC = 256
) (
   input  logic                  axi_clk,
   input  logic                  sys_areset,
   // AXI-Lite write address / data / response
   input  logic [AW_AXI-1:0]     awaddr,
   input  logic [2:0]            awprot,
   input  logic                  awvalid,
   output logic                  awready,
   input  logic [DW_AXI-1:0]     wdata,
   input  logic [DW_AXI/8-1:0]   wstrb,
   input  logic                  wvalid,
   output logic                  wready,
   output logic [1:0]            bresp,
   output logic                  bvalid,
   input  logic                  bready,
   // AXI-Lite read address / data
   input  logic [AW_AXI-1:0]     araddr,
   input  logic [2:0]            arprot,
   input  logic                  arvalid,
   output logic                  arready,
   output logic [DW_AXI-1:0]     rdata,
   output logic [1:0]            rresp,
   output logic                  rvalid,
   input  logic                  rready,
   // APB master
   output logic                  psel,
   output logic                  penable,
   output logic                  pwrite,
   output logic [AW_APB-1:0]     paddr,
   output logic [DW_APB-1:0]     pwdata,
   output logic [DW_APB/8-1:0]   pstrb,
   output logic [2:0]            pprot,
   input  logic [DW_APB-1:0]     prdata,
   input  logic                  pready,
   input  logic                  pslverr,
   // Debug view of the FSM
   output bridge_state_t         state_dbg
);

   bridge_state_t state, state_nxt;

   logic              prefer_read;   // round-robin flag, 0 = write-first
   logic              wr_cand, rd_cand;
   logic              grant_wr, grant_rd;
   logic [AW_AXI-1:0] sel_addr;
   logic [2:0]        sel_prot;
   logic              sel_dec_err;
   logic [1:0]        resp_q;
   logic [DW_AXI-1:0] rdata_q;
   logic              tmo_clear, tmo_enable, tmo_expired;

   assign wr_cand = awvalid & wvalid;
   assign rd_cand = arvalid;

   // Arbitration in IDLE: round-robin when both candidates are present.
   always_comb begin
      grant_wr = 1'b0;
      grant_rd = 1'b0;
      if ((state == IDLE) && !sys_areset) begin
         if (wr_cand && (!rd_cand || !prefer_read)) begin
            grant_wr = 1'b1;
         end else if (rd_cand) begin
            grant_rd = 1'b1;
         end
      end
   end

   assign awready  = grant_wr;
   assign wready   = grant_wr;
   assign arready  = grant_rd;
   assign sel_addr = grant_wr ? awaddr : araddr;
   assign sel_prot = grant_wr ? awprot : arprot;

   // Any address bit above the APB window is a decode error.
   generate
      if (AW_APB < AW_AXI) begin : g_decode
         assign sel_dec_err = |sel_addr[AW_AXI-1:AW_APB];
      end else begin : g_no_decode
         assign sel_dec_err = 1'b0;
      end
   endgenerate

   // State register.
   always_ff @(posedge axi_clk or posedge sys_areset) begin
      if (sys_areset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic and state-decoded strobes.
   always_comb begin
      state_nxt = state;
      psel      = 1'b0;
      penable   = 1'b0;
      bvalid    = 1'b0;
      rvalid    = 1'b0;
      case (state)
         IDLE: begin
            if (grant_wr || grant_rd) begin
               if (sel_dec_err) begin
                  state_nxt = grant_wr ? WRESP : RRESP;
               end else begin
                  state_nxt = SETUP;
               end
            end
         end
         SETUP: begin
            psel      = 1'b1;
            state_nxt = ACCESS;
         end
         ACCESS: begin
            psel    = 1'b1;
            penable = 1'b1;
            // PREADY takes priority over a simultaneous timeout.
            if (pready || tmo_expired) begin
               state_nxt = pwrite ? WRESP : RRESP;
            end
         end
         WRESP: begin
            bvalid = 1'b1;
            if (bready) begin
               state_nxt = IDLE;
            end
         end
         RRESP: begin
            rvalid = 1'b1;
            if (rready) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Datapath: request capture at grant, response capture at end of ACCESS.
   always_ff @(posedge axi_clk or posedge sys_areset) begin
      if (sys_areset) begin
         prefer_read <= 1'b0;
         pwrite      <= 1'b0;
         paddr       <= '0;
         pwdata      <= '0;
         pstrb       <= '0;
         pprot       <= '0;
         resp_q      <= RESP_OKAY;
         rdata_q     <= '0;
      end else begin
         if (grant_wr || grant_rd) begin
            prefer_read <= grant_wr;
            pwrite      <= grant_wr;
            paddr       <= sel_addr[AW_APB-1:0];
            pprot       <= sel_prot;
            pstrb       <= grant_wr ? wstrb : '0;
            if (grant_wr) begin
               pwdata <= wdata;
            end
            if (sel_dec_err) begin
               resp_q  <= RESP_DECERR;
               rdata_q <= '0;
            end
         end
         if (state == ACCESS) begin
            if (pready) begin
               resp_q <= pslverr ? RESP_SLVERR : RESP_OKAY;
               if (!pwrite) begin
                  rdata_q <= prdata;
               end
            end else if (tmo_expired) begin
               resp_q  <= RESP_SLVERR;
               rdata_q <= '0;
            end
         end
      end
   end

   assign bresp     = resp_q;
   assign rresp     = resp_q;
   assign rdata     = rdata_q;
   assign state_dbg = state;

   assign tmo_clear  = (state == SETUP);
   assign tmo_enable = (state == ACCESS) && !pready;

   apb_timeout_cnt #(
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_timeout (
      .clk     (axi_clk),
      .rst     (sys_areset),
      .clear   (tmo_clear),
      .enable  (tmo_enable),
      .expired (tmo_expired)
   );

endmodule

// File: tb/tb_axi_lite_to_apb_bridge.sv
// Self-checking bench for axi_lite_to_apb_bridge (TIMEOUT_CYC = 4).
module tb_axi_lite_to_apb_bridge;
   import axi_lite_apb_pkg::*;

   localparam int AW_AXI = 32;
   localparam int DW     = 32;
   localparam int AW_APB = 16;
   localparam int TMO    = 4;

   logic              clk;
   logic              rst;
   logic [AW_AXI-1:0] awaddr, araddr;
   logic [2:0]        awprot, arprot;
   logic              awvalid, awready, wvalid, wready, arvalid, arready;
   logic [DW-1:0]     wdata, rdata, pwdata, prdata;
   logic [DW/8-1:0]   wstrb, pstrb;
   logic [1:0]        bresp, rresp;
   logic              bvalid, bready, rvalid, rready;
   logic              psel, penable, pwrite, pready, pslverr;
   logic [AW_APB-1:0] paddr;
   logic [2:0]        pprot;
   bridge_state_t     state_dbg;

   int vectors     = 0;
   int miscompares = 0;
   int cyc_cnt     = 0;
   int last_grant_cyc;
   bit model_pref_write;
   logic [33:0] exp_q[$];   // {resp, rdata} expected per transaction

   axi_lite_to_apb_bridge #(
      .AW_AXI(AW_AXI), .DW_AXI(DW), .AW_APB(AW_APB), .DW_APB(DW), .TIMEOUT_CYC(TMO)
   ) dut (
      .axi_clk(clk), .sys_areset(rst),
      .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
      .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
      .bresp(bresp), .bvalid(bvalid), .bready(bready),
      .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
      .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
      .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
      .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot),
      .prdata(prdata), .pready(pready), .pslverr(pslverr),
      .state_dbg(state_dbg)
   );

   // Clock and cycle counter
   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   task automatic idle_inputs();
      awaddr = '0; awprot = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0;
      bready = 1'b0; araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b0;
      prdata = '0; pready = 1'b0; pslverr = 1'b0;
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst = 1'b1;
      idle_inputs();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      model_pref_write = 1'b1;
      exp_q.delete();
   endtask

   // Driver + checker for one transaction. Expected results come from the
   // protocol rules: decode error answers at grant+1 with DECERR, otherwise the
   // response is at grant+3+waits, or at grant+3+TMO with SLVERR when PREADY
   // would arrive later than TMO wait states.
   task automatic run_txn(input bit wr_req, input bit rd_req,
                          input logic [31:0] waddr, input logic [31:0] raddr,
                          input logic [31:0] wd, input logic [3:0] ws, input logic [2:0] prot,
                          input int waits, input bit slverr, input logic [31:0] rd_word,
                          input int hold, input string tag);
      bit is_wr, dec, got;
      logic [31:0] a;
      int exp_lat, c;
      logic [33:0] exp;
      logic [1:0] resp_obs;
      @(negedge clk);
      is_wr = wr_req && (!rd_req || model_pref_write);
      a     = is_wr ? waddr : raddr;
      dec   = (a >> AW_APB) != 0;
      if (dec) begin
         exp_lat = 1; exp = {RESP_DECERR, 32'h0};
      end else if (waits > TMO) begin
         exp_lat = TMO + 3; exp = {RESP_SLVERR, 32'h0};
      end else begin
         exp_lat = 3 + waits; exp = {(slverr ? RESP_SLVERR : RESP_OKAY), rd_word};
      end
      exp_q.push_back(exp);
      awaddr = waddr; awprot = prot; wdata = wd; wstrb = ws; awvalid = wr_req; wvalid = wr_req;
      araddr = raddr; arprot = prot; arvalid = rd_req;
      #1;
      vectors++;
      if ({awready, wready, arready} !== {is_wr, is_wr, !is_wr}) begin
         miscompares++;
         $display("FAIL %s grant: aw/w/ar ready=%b%b%b required %b%b%b", tag,
                  awready, wready, arready, is_wr, is_wr, !is_wr);
      end
      model_pref_write = !is_wr;
      last_grant_cyc = cyc_cnt;
      @(negedge clk);
      awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
      c = 1; got = 1'b0;
      while (c < 40 && !got) begin
         if (is_wr ? bvalid : rvalid) begin
            got = 1'b1;
         end else begin
            vectors++;
            if (dec) begin
               if (psel !== 1'b0) begin
                  miscompares++;
                  $display("FAIL %s decerr_psel: psel=%b required 0", tag, psel);
               end
            end else if (c == 1) begin
               if ({psel, penable, pwrite, paddr, pprot, pstrb} !==
                   {1'b1, 1'b0, is_wr, a[AW_APB-1:0], prot, (is_wr ? ws : 4'h0)} ||
                   (is_wr && pwdata !== wd)) begin
                  miscompares++;
                  $display("FAIL %s setup: sel/en/wr=%b%b%b addr=%h prot=%h strb=%h wdata=%h required 10%b %h %h %h %h",
                           tag, psel, penable, pwrite, paddr, pprot, pstrb, pwdata,
                           is_wr, a[AW_APB-1:0], prot, (is_wr ? ws : 4'h0), wd);
               end
            end else begin
               if ({psel, penable, pwrite, paddr} !== {1'b1, 1'b1, is_wr, a[AW_APB-1:0]}) begin
                  miscompares++;
                  $display("FAIL %s access: sel/en/wr=%b%b%b addr=%h required 11%b %h",
                           tag, psel, penable, pwrite, paddr, is_wr, a[AW_APB-1:0]);
               end
               pready  = (c - 2 == waits);
               pslverr = slverr;
               prdata  = pready ? rd_word : $urandom;
            end
            @(negedge clk);
            c++;
         end
      end
      pready = 1'b0; pslverr = 1'b0;
      exp = exp_q.pop_front();
      vectors++;
      if (!got || c != exp_lat) begin
         miscompares++;
         $display("FAIL %s latency: response at grant+%0d required grant+%0d", tag, c, exp_lat);
      end
      vectors++;
      if (psel !== 1'b0 || penable !== 1'b0) begin
         miscompares++;
         $display("FAIL %s resp_psel: psel/penable=%b%b required 00", tag, psel, penable);
      end
      for (int h = 0; h <= hold; h++) begin
         if (h > 0) @(negedge clk);
         resp_obs = is_wr ? bresp : rresp;
         vectors++;
         if ((is_wr ? bvalid : rvalid) !== 1'b1 || resp_obs !== exp[33:32] ||
             (!is_wr && rdata !== exp[31:0])) begin
            miscompares++;
            $display("FAIL %s response: valid=%b resp=%b rdata=%h required 1 %b %h", tag,
                     (is_wr ? bvalid : rvalid), resp_obs, rdata, exp[33:32],
                     (is_wr ? rdata : exp[31:0]));
         end
      end
      bready = is_wr; rready = !is_wr;
      @(posedge clk);
      #1;
      bready = 1'b0; rready = 1'b0;
      vectors++;
      if (bvalid !== 1'b0 || rvalid !== 1'b0 || state_dbg !== IDLE) begin
         miscompares++;
         $display("FAIL %s release: bvalid=%b rvalid=%b state=%0d required 0 0 IDLE",
                  tag, bvalid, rvalid, state_dbg);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      idle_inputs();
      awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
      repeat (2) @(negedge clk);
      vectors++;
      if ({awready, wready, arready, bvalid, bresp, rvalid, rdata, rresp, psel, penable, pwrite,
           paddr, pwdata, pstrb, pprot} !== '0) begin
         miscompares++;
         $display("FAIL reset_outputs: rdys=%b%b%b bv=%b rv=%b psel=%b pen=%b paddr=%h pwdata=%h",
                  awready, wready, arready, bvalid, rvalid, psel, penable, paddr, pwdata);
      end
      idle_inputs();
      rst = 1'b0;
      model_pref_write = 1'b1;
   endtask

   task automatic test_write();
      run_txn(1, 0, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, 4'hF, 3'b000, 0, 0, 32'h0, 1, "write_basic");
   endtask

   task automatic test_read_wait_slverr();
      run_txn(0, 1, 32'h0, 32'h0000_0024, 32'h0, 4'h0, 3'b010, 2, 1, 32'h1234_5678, 0, "read_slverr");
   endtask

   task automatic test_arbitration();
      apply_reset();
      run_txn(1, 1, 32'h100, 32'h200, 32'hA5A5_0001, 4'h3, 3'b001, 0, 0, 32'h1111_2222, 0, "arb1_write");
      run_txn(1, 1, 32'h104, 32'h204, 32'hA5A5_0002, 4'hC, 3'b001, 0, 0, 32'h3333_4444, 0, "arb2_read");
      run_txn(1, 1, 32'h108, 32'h208, 32'hA5A5_0003, 4'hF, 3'b001, 1, 0, 32'h5555_6666, 0, "arb3_write");
   endtask

   task automatic test_decerr();
      run_txn(1, 0, 32'h0001_0010, 32'h0, 32'hCAFE_0000, 4'hF, 3'b000, 0, 0, 32'h0, 0, "decerr_write");
      run_txn(0, 1, 32'h0, 32'h8000_0024, 32'h0, 4'h0, 3'b000, 0, 0, 32'hFFFF_FFFF, 0, "decerr_read");
   endtask

   task automatic test_timeout();
      run_txn(1, 0, 32'h0000_0030, 32'h0, 32'h0BAD_F00D, 4'hF, 3'b000, 99, 0, 32'h0, 0, "timeout_write");
      run_txn(0, 1, 32'h0, 32'h0000_0034, 32'h0, 4'h0, 3'b000, 0, 0, 32'h7777_8888, 0, "after_timeout_read");
      run_txn(0, 1, 32'h0, 32'h0000_0038, 32'h0, 4'h0, 3'b000, TMO, 0, 32'h9999_AAAA, 0, "pready_at_limit");
   endtask

   task automatic test_partial();
      @(negedge clk);
      awvalid = 1'b1; awaddr = 32'h40;
      repeat (3) begin
         @(negedge clk);
         vectors++;
         if ({awready, wready, arready, psel} !== 4'b0000 || state_dbg !== IDLE) begin
            miscompares++;
            $display("FAIL aw_only: rdys=%b%b%b psel=%b state=%0d required 0000 IDLE",
                     awready, wready, arready, psel, state_dbg);
         end
      end
      awvalid = 1'b0; wvalid = 1'b1;
      repeat (3) begin
         @(negedge clk);
         vectors++;
         if ({awready, wready, arready, psel} !== 4'b0000 || state_dbg !== IDLE) begin
            miscompares++;
            $display("FAIL w_only: rdys=%b%b%b psel=%b state=%0d required 0000 IDLE",
                     awready, wready, arready, psel, state_dbg);
         end
      end
      wvalid = 1'b0;
   endtask

   task automatic test_back_to_back();
      int g0, g1;
      run_txn(1, 0, 32'h50, 32'h0, 32'h1, 4'hF, 3'b000, 0, 0, 32'h0, 0, "b2b_0");
      g0 = last_grant_cyc;
      run_txn(0, 1, 32'h0, 32'h54, 32'h0, 4'h0, 3'b000, 0, 0, 32'h2, 0, "b2b_1");
      g1 = last_grant_cyc;
      vectors++;
      if (g1 - g0 != 4) begin
         miscompares++;
         $display("FAIL b2b_period: grant spacing=%0d required 4", g1 - g0);
      end
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      awaddr = 32'h60; awprot = 3'b011; wdata = 32'h5555_AAAA; wstrb = 4'hF;
      awvalid = 1'b1; wvalid = 1'b1;
      @(negedge clk);
      awvalid = 1'b0; wvalid = 1'b0;
      @(negedge clk);
      vectors++;
      if ({psel, penable} !== 2'b11) begin
         miscompares++;
         $display("FAIL rstmid_access: psel/penable=%b%b required 11", psel, penable);
      end
      #2 rst = 1'b1;
      #1;
      vectors++;
      if ({bvalid, bresp, rvalid, rdata, rresp, psel, penable, pwrite, paddr, pwdata, pstrb, pprot} !== '0) begin
         miscompares++;
         $display("FAIL rstmid_outputs: psel=%b pen=%b pwrite=%b paddr=%h pwdata=%h pstrb=%h pprot=%h required all 0",
                  psel, penable, pwrite, paddr, pwdata, pstrb, pprot);
      end
      @(negedge clk);
      rst = 1'b0;
      model_pref_write = 1'b1;
      repeat (6) begin
         @(negedge clk);
         vectors++;
         if (bvalid !== 1'b0 || psel !== 1'b0) begin
            miscompares++;
            $display("FAIL rstmid_after: bvalid=%b psel=%b required 0 0", bvalid, psel);
         end
      end
   endtask

   task automatic test_random();
      bit wr, rd;
      logic [31:0] wa, ra;
      for (int n = 0; n < 24; n++) begin
         wr = $urandom_range(0, 1);
         rd = !wr || ($urandom_range(0, 1) == 1);
         wa = {16'h0, $urandom_range(0, 16'hFFFF)} & 32'hFFFF_FFFC;
         ra = {16'h0, $urandom_range(0, 16'hFFFF)} & 32'hFFFF_FFFC;
         if ($urandom_range(0, 5) == 0) wa[AW_APB + $urandom_range(0, 15)] = 1'b1;
         if ($urandom_range(0, 5) == 0) ra[AW_APB + $urandom_range(0, 15)] = 1'b1;
         run_txn(wr, rd, wa, ra, $urandom, 4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)),
                 $urandom_range(0, 6), 1'($urandom_range(0, 1)), $urandom,
                 $urandom_range(0, 2), $sformatf("rand%0d", n));
      end
   endtask

   initial begin
      idle_inputs();
      rst = 1'b1;
      model_pref_write = 1'b1;
      test_reset();
      test_write();
      test_read_wait_slverr();
      test_arbitration();
      test_decerr();
      test_timeout();
      test_partial();
      test_back_to_back();
      test_reset_mid();
      test_random();
      repeat (2) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   // Absolute time limit so the run always terminates.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
